apb_rr_arbiter: RTL and testbench

Round-robin APB arbiter and sequencer that shares one APB completer (the 0xA000 adder register slave and its peers) between NUM_REQ on-chip requesters. Each requester issues a simple single-transfer command; the arbiter grants one at a time, latches its command, drives the full APB SETUP/ACCESS sequence, and returns read data, completion and a timeout error. It sits between requester logic (adder/control engines) and the APB completer bus.

---
 rtl/apb_rr_arbiter_pkg.sv | 25 ++
 rtl/apb_rr_arbiter_if.sv | 23 ++
 rtl/apb_rr_pick.sv | 27 ++
 rtl/apb_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_apb_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types for the round-robin APB arbiter: FSM states, the latched command
// and the wait-counter width helper.
package apb_arb_pkg;

   localparam int APB_MAX_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } apb_arb_state_t;

   // Address and data are held at full APB width and sliced down to the bus widths.
   typedef struct packed {
      logic                 write;
      logic [APB_MAX_W-1:0] addr;
      logic [APB_MAX_W-1:0] wdata;
   } apb_cmd_t;

   // A width of 1 keeps the counter legal when the timeout is disabled.
   function automatic int cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// APB completer-side bus: the arbiter is the master, the shared completer the slave.
interface apb_rr_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              psel_o;
   logic              penable_o;
   logic [ADDR_W-1:0] paddr_o;
   logic              pwrite_o;
   logic [DATA_W-1:0] pwdata_o;
   logic [DATA_W-1:0] prdata_i;
   logic              pready_i;

   modport master (
      output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
      input  prdata_i, pready_i
   );

   modport slave (
      input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
      output prdata_i, pready_i
   );
endinterface

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first eligible index after 'last', wrapping.
module apb_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] last,
   output logic             valid,
   output logic [IDX_W-1:0] winner
);
   logic [N-1:0][IDX_W-1:0] cand;
   logic [N-1:0]            hit;

   // cand[gi] is the requester at distance gi+1 from the previous owner.
   for (genvar gi = 0; gi < N; gi++) begin : g_off
      assign cand[gi] = IDX_W'((int'(last) + gi + 1) % N);
      assign hit[gi]  = eligible[cand[gi]];
   end

   always_comb begin
      valid  = |eligible;
      winner = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (hit[i]) winner = cand[i];
      end
   end
endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB completer between NUM_REQ requesters:
// grants one command at a time, runs SETUP/ACCESS, returns data, done and timeout.
module apb_rr_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                            pclk,
   input  logic                            preset_n,
   input  logic [NUM_REQ-1:0]              req_i,
   input  logic [NUM_REQ-1:0]              req_write_i,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata_i,
   output logic [NUM_REQ-1:0]              done_o,
   output logic [NUM_REQ-1:0]              err_o,
   output logic [DATA_W-1:0]               rdata_o,
   apb_rr_arbiter_if.master                apb
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   apb_arb_state_t     state_reg, state_next;
   apb_cmd_t           cmd_reg, cmd_next;
   logic [IDX_W-1:0]   owner_reg, owner_next;
   logic [IDX_W-1:0]   last_reg, last_next;
   logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
   logic [NUM_REQ-1:0] done_reg, done_next;
   logic [NUM_REQ-1:0] err_reg, err_next;
   logic [DATA_W-1:0]  rdata_reg, rdata_next;

   logic [NUM_REQ-1:0] eligible;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic               busy;

   // A requester whose done is pulsing this cycle may still show req high.
   assign eligible = req_i & ~done_reg;

   apb_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .eligible (eligible),
      .last     (last_reg),
      .valid    (pick_valid),
      .winner   (pick_idx)
   );

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_reg    <= ST_IDLE;
         cmd_reg      <= '0;
         owner_reg    <= '0;
         last_reg     <= IDX_W'(NUM_REQ - 1);
         wait_cnt_reg <= '0;
         done_reg     <= '0;
         err_reg      <= '0;
         rdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         cmd_reg      <= cmd_next;
         owner_reg    <= owner_next;
         last_reg     <= last_next;
         wait_cnt_reg <= wait_cnt_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         rdata_reg    <= rdata_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cmd_next      = cmd_reg;
      owner_next    = owner_reg;
      last_next     = last_reg;
      wait_cnt_next = wait_cnt_reg;
      done_next     = '0;
      err_next      = '0;
      rdata_next    = rdata_reg;

      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               owner_next     = pick_idx;
               cmd_next.write = req_write_i[pick_idx];
               cmd_next.addr  = APB_MAX_W'(req_addr_i[pick_idx]);
               cmd_next.wdata = APB_MAX_W'(req_wdata_i[pick_idx]);
               wait_cnt_next  = '0;
               state_next     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (apb.pready_i) begin
               if (!cmd_reg.write) rdata_next = apb.prdata_i;
               done_next[owner_reg] = 1'b1;
               last_next            = owner_reg;
               state_next           = ST_IDLE;
            end else if (TIMEOUT != 0 && wait_cnt_reg == TIMEOUT_LAST) begin
               done_next[owner_reg] = 1'b1;
               err_next[owner_reg]  = 1'b1;
               last_next            = owner_reg;
               state_next           = ST_IDLE;
            end else if (wait_cnt_reg != '1) begin
               wait_cnt_next = wait_cnt_reg + CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Bus outputs decode straight from the state register so reset clears them at once.
   assign busy          = (state_reg != ST_IDLE);
   assign apb.psel_o    = busy;
   assign apb.penable_o = (state_reg == ST_ACCESS);
   assign apb.pwrite_o  = busy & cmd_reg.write;
   assign apb.paddr_o   = busy ? cmd_reg.addr[ADDR_W-1:0] : '0;
   assign apb.pwdata_o  = busy ? cmd_reg.wdata[DATA_W-1:0] : '0;

   assign done_o  = done_reg;
   assign err_o   = err_reg;
   assign rdata_o = rdata_reg;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: table of single transfers through a
// scoreboard, plus hand-written timing, reset and round-robin sequences.
module tb_apb_rr_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;
   localparam logic [31:0] RD_PAT  = 32'h5A5A_0000;
   localparam logic [31:0] REG_ADR = 32'h0000_A000;

   logic                           pclk = 1'b0;
   logic                           preset_n = 1'b0;
   logic [NUM_REQ-1:0]             req = '0;
   logic [NUM_REQ-1:0]             req_write = '0;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata = '0;
   logic [NUM_REQ-1:0]             done;
   logic [NUM_REQ-1:0]             err;
   logic [DATA_W-1:0]              rdata;

   apb_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .pclk        (pclk),
      .preset_n    (preset_n),
      .req_i       (req),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .done_o      (done),
      .err_o       (err),
      .rdata_o     (rdata),
      .apb         (apb)
   );

   always #5 pclk = ~pclk;

   // Completer model: register at 0xA000, address-derived data elsewhere.
   int          slave_waits = 0;
   bit          slave_never = 1'b0;
   logic [31:0] slave_reg = 32'h5;
   int          acc_cnt = 0;

   always @(posedge pclk) begin
      if (apb.psel_o && apb.penable_o) begin
         if (apb.pready_i && apb.pwrite_o && apb.paddr_o == REG_ADR) slave_reg <= apb.pwdata_o;
         acc_cnt <= apb.pready_i ? 0 : acc_cnt + 1;
      end else begin
         acc_cnt <= 0;
      end
   end

   assign apb.pready_i = apb.psel_o && apb.penable_o && !slave_never && (acc_cnt >= slave_waits);
   assign apb.prdata_i = (apb.paddr_o == REG_ADR) ? slave_reg : (apb.paddr_o ^ RD_PAT);

   typedef struct {
      logic [NUM_REQ-1:0] done;
      logic               err;
      logic [31:0]        rdata;
      logic [31:0]        addr;
      logic               wr;
      logic [31:0]        wdata;
      int                 acc;
   } exp_t;

   typedef struct {
      int          r;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      bit          never;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   acc_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Bus monitor: checks the latched command on the wire and retires completions.
   always @(negedge pclk) begin
      if (!preset_n) begin
         acc_seen = 0;
      end else begin
         if (apb.psel_o) begin
            if (sb.size() == 0) begin
               check("unexpected_psel", 32'(apb.psel_o), 32'd0);
            end else begin
               if (!apb.penable_o) acc_seen = 0;
               else acc_seen++;
               check("paddr", apb.paddr_o, sb[0].addr);
               check("pwrite", 32'(apb.pwrite_o), 32'(sb[0].wr));
               check("pwdata", apb.pwdata_o, sb[0].wdata);
            end
         end
         if (done != '0 || err != '0) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("done", 32'(done), 32'(mon_e.done));
               check("err", 32'(err), mon_e.err ? 32'(mon_e.done) : 32'd0);
               check("rdata", rdata, mon_e.rdata);
               check("access_cycles", 32'(acc_seen), 32'(mon_e.acc));
               $display("xfer done=%b err=%b addr=%h wr=%0d rdata=%h access=%0d",
                        done, err, mon_e.addr, mon_e.wr, rdata, acc_seen);
            end
         end
      end
   end

   task automatic push_exp(input int r, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input bit never,
                           input logic exp_err, input logic [31:0] exp_rdata);
      exp_t e;
      e.done  = NUM_REQ'(1 << r);
      e.err   = exp_err;
      e.rdata = exp_rdata;
      e.addr  = addr;
      e.wr    = wr;
      e.wdata = wdata;
      e.acc   = never ? TIMEOUT : waits + 1;
      sb.push_back(e);
      req_write[r] = wr;
      req_addr[r]  = addr;
      req_wdata[r] = wdata;
   endtask

   // Drops each request in its done cycle; a request still pending at the bound is a failure.
   task automatic wait_drop(input logic [NUM_REQ-1:0] mask);
      for (int i = 0; i < 300; i++) begin
         @(negedge pclk);
         req = req & ~done;
         if ((req & mask) == '0) break;
      end
      check("req_served", 32'(req & mask), 32'd0);
      req = req & ~mask;
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge pclk);
      slave_waits = v.waits;
      slave_never = v.never;
      push_exp(v.r, v.wr, v.addr, v.wdata, v.waits, v.never, v.exp_err, v.exp_rdata);
      req[v.r] = 1'b1;
      wait_drop(NUM_REQ'(1 << v.r));
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{r:1, wr:1'b0, addr:32'h0000_A000, wdata:32'h0,         waits:3, never:1'b0, exp_err:1'b0, exp_rdata:32'h5};
      vecs[1] = '{r:3, wr:1'b1, addr:32'h0000_0100, wdata:32'hDEAD_BEEF, waits:0, never:1'b0, exp_err:1'b0, exp_rdata:32'h5};
      vecs[2] = '{r:2, wr:1'b0, addr:32'h0000_A010, wdata:32'h1111_2222, waits:1, never:1'b0, exp_err:1'b0, exp_rdata:32'h5A5A_A010};
      vecs[3] = '{r:1, wr:1'b0, addr:32'h0000_A000, wdata:32'h0,         waits:0, never:1'b1, exp_err:1'b1, exp_rdata:32'h5A5A_A010};
      vecs[4] = '{r:0, wr:1'b0, addr:32'h0000_A000, wdata:32'h0,         waits:0, never:1'b0, exp_err:1'b0, exp_rdata:32'h5};
      vecs[5] = '{r:2, wr:1'b1, addr:32'h0000_A000, wdata:32'h7,         waits:0, never:1'b0, exp_err:1'b0, exp_rdata:32'h5};
      vecs[6] = '{r:2, wr:1'b0, addr:32'h0000_A000, wdata:32'h0,         waits:0, never:1'b0, exp_err:1'b0, exp_rdata:32'h7};
      vecs[7] = '{r:2, wr:1'b1, addr:32'h0000_A000, wdata:32'h8,         waits:0, never:1'b0, exp_err:1'b0, exp_rdata:32'h7};
      vecs[8] = '{r:2, wr:1'b0, addr:32'h0000_A000, wdata:32'h0,         waits:2, never:1'b0, exp_err:1'b0, exp_rdata:32'h8};

      // Reset state
      repeat (3) @(negedge pclk);
      check("rst_psel", 32'(apb.psel_o), 32'd0);
      check("rst_penable", 32'(apb.penable_o), 32'd0);
      check("rst_paddr", apb.paddr_o, 32'd0);
      check("rst_pwrite", 32'(apb.pwrite_o), 32'd0);
      check("rst_pwdata", apb.pwdata_o, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      preset_n = 1'b1;

      // Single read, cycle-exact: SETUP at T+1, ACCESS at T+2, done at T+3
      @(negedge pclk);
      slave_waits = 0;
      slave_never = 1'b0;
      push_exp(0, 1'b0, REG_ADR, 32'h0, 0, 1'b0, 1'b0, 32'h5);
      req[0] = 1'b1;
      @(negedge pclk);
      check("t1_psel", 32'(apb.psel_o), 32'd1);
      check("t1_penable", 32'(apb.penable_o), 32'd0);
      @(negedge pclk);
      check("t2_penable", 32'(apb.penable_o), 32'd1);
      @(negedge pclk);
      check("t3_done", 32'(done), 32'h1);
      check("t3_rdata", rdata, 32'h5);
      req = req & ~done;
      wait_drop(4'b0001);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Reset in the middle of ACCESS
      @(negedge pclk);
      slave_never = 1'b1;
      push_exp(3, 1'b0, REG_ADR, 32'h0, 0, 1'b1, 1'b1, 32'h8);
      req[3] = 1'b1;
      for (int i = 0; i < 20 && !apb.penable_o; i++) @(negedge pclk);
      check("mid_penable", 32'(apb.penable_o), 32'd1);
      #2 preset_n = 1'b0;
      #1;
      check("mid_rst_psel", 32'(apb.psel_o), 32'd0);
      check("mid_rst_penable", 32'(apb.penable_o), 32'd0);
      check("mid_rst_paddr", apb.paddr_o, 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      sb.delete();
      req = '0;
      repeat (3) begin
         @(negedge pclk);
         check("mid_rst_no_done", 32'(done), 32'd0);
      end
      preset_n = 1'b1;

      // All four held: served 0,1,2,3, then 0 before 1 after re-request
      @(negedge pclk);
      slave_waits = 0;
      slave_never = 1'b0;
      for (int r = 0; r < NUM_REQ; r++)
         push_exp(r, 1'b0, 32'(r * 32'h100 + 32'h10), 32'(r), 0, 1'b0, 1'b0,
                  32'(r * 32'h100 + 32'h10) ^ RD_PAT);
      req = 4'b1111;
      wait_drop(4'b1111);
      @(negedge pclk);
      push_exp(0, 1'b1, 32'h0000_0200, 32'hCAFE_0000, 0, 1'b0, 1'b0, 32'h5A5A_0310);
      push_exp(1, 1'b0, 32'h0000_0300, 32'h0,         0, 1'b0, 1'b0, 32'h5A5A_0300);
      req = 4'b0011;
      wait_drop(4'b0011);
      repeat (2) @(negedge pclk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
